// File: rtl/dmem_interface_pkg.sv
// Shared LSU types: FSM state encoding, access size encodings and the alignment rule.
package p_hardisc;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    WAIT  = 2'b10,
    DRAIN = 2'b11
  } lsu_state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Size 2'b11 is not a legal access and is reported like a misaligned one.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = off[0];
      SIZE_W:  mis = (off != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_interface_lsu_align.sv
// Byte-lane steering: store byte-enables and data replication on the request side,
// load byte/half extraction and sign/zero extension on the response side.
module lsu_align
  import p_hardisc::*;
(
  input  logic [1:0]      req_size_i,
  input  logic [1:0]      req_off_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic [BE_W-1:0] be_o,
  output logic [XLEN-1:0] wdata_o,
  input  logic [1:0]      rsp_size_i,
  input  logic [1:0]      rsp_off_i,
  input  logic            rsp_unsigned_i,
  input  logic [XLEN-1:0] rsp_rdata_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] shifted;
  logic            sext;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = req_wdata_i;
    case (req_size_i)
      SIZE_B: begin
        be_o    = 4'b0001 << req_off_i;
        wdata_o = {4{req_wdata_i[7:0]}};
      end
      SIZE_H: begin
        be_o    = 4'b0011 << req_off_i;
        wdata_o = {2{req_wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = req_wdata_i;
      end
    endcase
  end

  always_comb begin
    shifted = rsp_rdata_i >> {rsp_off_i, 3'b000};
    sext    = 1'b0;
    rdata_o = rsp_rdata_i;
    case (rsp_size_i)
      SIZE_B: begin
        sext    = ~rsp_unsigned_i & shifted[7];
        rdata_o = {{24{sext}}, shifted[7:0]};
      end
      SIZE_H: begin
        sext    = ~rsp_unsigned_i & shifted[15];
        rdata_o = {{16{sext}}, shifted[15:0]};
      end
      default: rdata_o = rsp_rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_interface.sv
// Data-memory load/store unit: accepts one EX-stage access at a time, runs the
// req/gnt/rvalid bus handshake and returns the extended load result.
module dmem_interface
  import p_hardisc::*;
(
  input  logic            s_clk_i,
  input  logic            s_resetn_i,
  input  logic            s_flush_i,
  input  logic            s_valid_i,
  input  logic            s_store_i,
  input  logic [1:0]      s_size_i,
  input  logic            s_unsigned_i,
  input  logic [XLEN-1:0] s_address_i,
  input  logic [XLEN-1:0] s_wdata_i,
  output logic            s_ready_o,
  output logic            s_stall_o,
  output logic            s_dmem_req_o,
  output logic            s_dmem_we_o,
  output logic [XLEN-1:0] s_dmem_addr_o,
  output logic [BE_W-1:0] s_dmem_be_o,
  output logic [XLEN-1:0] s_dmem_wdata_o,
  input  logic            s_dmem_gnt_i,
  input  logic            s_dmem_rvalid_i,
  input  logic [XLEN-1:0] s_dmem_rdata_i,
  input  logic            s_dmem_err_i,
  output logic            s_done_o,
  output logic [XLEN-1:0] s_rdata_o,
  output logic            s_misaligned_o,
  output logic            s_bus_err_o
);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [BE_W-1:0] be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            mis_q, mis_d;
  logic            err_q, err_d;

  logic [BE_W-1:0] align_be;
  logic [XLEN-1:0] align_wdata;
  logic [XLEN-1:0] align_rdata;
  logic            accept;
  logic            req_mis;

  lsu_align u_align (
    .req_size_i     (s_size_i),
    .req_off_i      (s_address_i[1:0]),
    .req_wdata_i    (s_wdata_i),
    .be_o           (align_be),
    .wdata_o        (align_wdata),
    .rsp_size_i     (size_q),
    .rsp_off_i      (addr_q[1:0]),
    .rsp_unsigned_i (uns_q),
    .rsp_rdata_i    (s_dmem_rdata_i),
    .rdata_o        (align_rdata)
  );

  assign accept  = (state_q == IDLE) & s_valid_i & ~s_flush_i;
  assign req_mis = is_misaligned(s_size_i, s_address_i[1:0]);

  // Flush withdraws a pending request in the same cycle.
  assign s_ready_o    = accept;
  assign s_dmem_req_o = (state_q == REQ) & ~s_flush_i;

  // In DRAIN a waiting EX access cannot be taken yet, so it must hold too.
  always_comb begin
    s_stall_o = 1'b0;
    case (state_q)
      IDLE:    s_stall_o = s_valid_i & s_flush_i;
      REQ:     s_stall_o = 1'b1;
      WAIT:    s_stall_o = 1'b1;
      DRAIN:   s_stall_o = s_valid_i;
      default: s_stall_o = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    done_d  = 1'b0;
    rdata_d = '0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_mis) begin
            mis_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = REQ;
            addr_d  = s_address_i;
            be_d    = align_be;
            wdata_d = align_wdata;
            we_d    = s_store_i;
            size_d  = s_size_i;
            uns_d   = s_unsigned_i;
          end
        end
      end
      REQ: begin
        if (s_flush_i) begin
          state_d = s_dmem_gnt_i ? DRAIN : IDLE;
        end else if (s_dmem_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (s_dmem_rvalid_i) begin
          state_d = IDLE;
          if (!s_flush_i) begin
            done_d  = 1'b1;
            err_d   = s_dmem_err_i;
            rdata_d = we_q ? '0 : align_rdata;
          end
        end else if (s_flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (s_dmem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign s_dmem_we_o    = we_q;
  assign s_dmem_addr_o  = {addr_q[XLEN-1:2], 2'b00};
  assign s_dmem_be_o    = be_q;
  assign s_dmem_wdata_o = wdata_q;
  assign s_done_o       = done_q;
  assign s_rdata_o      = rdata_q;
  assign s_misaligned_o = mis_q;
  assign s_bus_err_o    = err_q;

endmodule

// File: tb/tb_dmem_interface.sv
// Directed bench for dmem_interface: per-scenario tasks with hand-computed expectations.
module tb_dmem_interface;

  logic        clk;
  logic        rst_n;
  logic        flush, valid, store, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ready, stall;
  logic        req, we;
  logic [31:0] daddr, dwdata;
  logic [3:0]  be;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  logic        done, mis, berr;
  logic [31:0] rdata_o;

  int checks;
  int errors;

  dmem_interface dut (
    .s_clk_i         (clk),
    .s_resetn_i      (rst_n),
    .s_flush_i       (flush),
    .s_valid_i       (valid),
    .s_store_i       (store),
    .s_size_i        (size),
    .s_unsigned_i    (uns),
    .s_address_i     (addr),
    .s_wdata_i       (wdata),
    .s_ready_o       (ready),
    .s_stall_o       (stall),
    .s_dmem_req_o    (req),
    .s_dmem_we_o     (we),
    .s_dmem_addr_o   (daddr),
    .s_dmem_be_o     (be),
    .s_dmem_wdata_o  (dwdata),
    .s_dmem_gnt_i    (gnt),
    .s_dmem_rvalid_i (rvalid),
    .s_dmem_rdata_i  (rdata),
    .s_dmem_err_i    (err),
    .s_done_o        (done),
    .s_rdata_o       (rdata_o),
    .s_misaligned_o  (mis),
    .s_bus_err_o     (berr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; valid = 0; store = 0; size = 2'b00; uns = 0;
    addr = '0; wdata = '0; gnt = 0; rvalid = 0; rdata = '0; err = 0;
  endtask

  // Present one access; it is taken at the next edge.
  task automatic present(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd);
    valid = 1; store = st; size = sz; uns = un; addr = a; wdata = wd;
  endtask

  task automatic test_reset();
    logic [107:0] got;
    idle_inputs();
    rst_n = 0;
    step(); step();
    got = {req, we, be, daddr, dwdata, done, rdata_o, mis, berr, stall};
    checks++;
    if (got !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", got);
    end
    rst_n = 1;
    step();
  endtask

  task automatic test_word_load();
    present(0, 2'b10, 0, 32'h100, 32'h0);
    #1;
    checks++;
    if ({ready, req, stall} !== 3'b100) begin
      errors++; $display("FAIL word_accept: got %b expected 100", {ready, req, stall});
    end
    step();
    valid = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) gnt = 1;
      #1;
      checks++;
      if ({req, we, be, daddr, stall} !== {1'b1, 1'b0, 4'hF, 32'h100, 1'b1}) begin
        errors++; $display("FAIL word_req_hold%0d: got %h expected %h", c,
          {req, we, be, daddr, stall}, {1'b1, 1'b0, 4'hF, 32'h100, 1'b1});
      end
      step();
    end
    gnt = 0;
    checks++;
    if ({req, stall, done} !== 3'b010) begin
      errors++; $display("FAIL word_wait: got %b expected 010", {req, stall, done});
    end
    rvalid = 1; rdata = 32'hDEADBEEF;
    step();
    rvalid = 0;
    checks++;
    if ({done, rdata_o, berr, stall} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0}) begin
      errors++; $display("FAIL word_done: got done=%b rdata=%h err=%b stall=%b expected 1 deadbeef 0 0",
        done, rdata_o, berr, stall);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL word_done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_byte_load(input logic un, input logic [31:0] exp);
    present(0, 2'b00, un, 32'h103, 32'h0);
    step();
    valid = 0;
    checks++;
    if ({req, be, daddr} !== {1'b1, 4'b1000, 32'h100}) begin
      errors++; $display("FAIL byte_req_u%0d: got req=%b be=%b addr=%h expected 1 1000 100",
        un, req, be, daddr);
    end
    gnt = 1;
    step();
    gnt = 0; rvalid = 1; rdata = 32'h80FFFFFF;
    step();
    rvalid = 0;
    checks++;
    if ({done, rdata_o} !== {1'b1, exp}) begin
      errors++; $display("FAIL byte_rdata_u%0d: got done=%b rdata=%h expected 1 %h", un, done, rdata_o, exp);
    end
    step();
  endtask

  task automatic test_half_store();
    present(1, 2'b01, 0, 32'h102, 32'h1234ABCD);
    step();
    valid = 0; store = 0;
    checks++;
    if ({req, we, be, dwdata, daddr} !== {1'b1, 1'b1, 4'b1100, 32'hABCDABCD, 32'h100}) begin
      errors++; $display("FAIL half_store_bus: got req=%b we=%b be=%b wdata=%h addr=%h expected 1 1 1100 abcdabcd 100",
        req, we, be, dwdata, daddr);
    end
    gnt = 1;
    step();
    gnt = 0; rvalid = 1; rdata = 32'hFFFFFFFF;
    step();
    rvalid = 0;
    checks++;
    if ({done, rdata_o} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL half_store_done: got done=%b rdata=%h expected 1 0", done, rdata_o);
    end
    step();
  endtask

  task automatic test_misaligned();
    logic [1:0]  sz [3];
    logic [31:0] ad [3];
    sz = '{2'b10, 2'b01, 2'b11};
    ad = '{32'h101, 32'h103, 32'h100};
    for (int i = 0; i < 3; i++) begin
      present(0, sz[i], 0, ad[i], 32'h0);
      step();
      valid = 0;
      checks++;
      if ({mis, done, req, stall} !== 4'b1100) begin
        errors++; $display("FAIL misaligned%0d: got %b expected 1100", i, {mis, done, req, stall});
      end
      step();
      checks++;
      if ({mis, done, req} !== 3'b000) begin
        errors++; $display("FAIL misaligned_pulse%0d: got %b expected 000", i, {mis, done, req});
      end
    end
  endtask

  task automatic test_flush_wait();
    present(0, 2'b10, 0, 32'h200, 32'h0);
    step();
    valid = 0; gnt = 1;
    step();
    gnt = 0; flush = 1;
    step();
    flush = 0;
    present(0, 2'b10, 0, 32'h300, 32'h0);
    #1;
    checks++;
    if ({ready, req} !== 2'b00) begin
      errors++; $display("FAIL drain_ready: got %b expected 00", {ready, req});
    end
    rvalid = 1; err = 1; rdata = 32'h1234;
    step();
    rvalid = 0; err = 0;
    #1;
    checks++;
    if ({done, berr, ready} !== 3'b001) begin
      errors++; $display("FAIL drain_exit: got %b expected 001", {done, berr, ready});
    end
    valid = 0;
    step();
    checks++;
    if ({done, req} !== 2'b00) begin
      errors++; $display("FAIL drain_after: got %b expected 00", {done, req});
    end
  endtask

  task automatic test_flush_req();
    present(0, 2'b10, 0, 32'h400, 32'h0);
    step();
    valid = 0; flush = 1;
    #1;
    checks++;
    if (req !== 1'b0) begin
      errors++; $display("FAIL flush_req_drop: got %b expected 0", req);
    end
    step();
    flush = 0;
    present(0, 2'b10, 0, 32'h400, 32'h0);
    #1;
    checks++;
    if ({done, req, ready} !== 3'b001) begin
      errors++; $display("FAIL flush_req_idle: got %b expected 001", {done, req, ready});
    end
    valid = 0;
    step();
  endtask

  task automatic test_flush_idle_stall();
    present(0, 2'b10, 0, 32'h500, 32'h0);
    flush = 1;
    #1;
    checks++;
    if ({ready, stall} !== 2'b01) begin
      errors++; $display("FAIL idle_flush_stall: got %b expected 01", {ready, stall});
    end
    step();
    valid = 0; flush = 0;
    checks++;
    if ({req, done} !== 2'b00) begin
      errors++; $display("FAIL idle_flush_noaccept: got %b expected 00", {req, done});
    end
  endtask

  task automatic test_bus_err();
    present(0, 2'b10, 0, 32'h600, 32'h0);
    step();
    valid = 0; gnt = 1;
    step();
    gnt = 0; rvalid = 1; err = 1; rdata = 32'hCAFEF00D;
    step();
    rvalid = 0; err = 0;
    checks++;
    if ({done, berr, rdata_o} !== {1'b1, 1'b1, 32'hCAFEF00D}) begin
      errors++; $display("FAIL bus_err: got done=%b err=%b rdata=%h expected 1 1 cafef00d", done, berr, rdata_o);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [106:0] got;
    present(1, 2'b10, 0, 32'h700, 32'h55AA55AA);
    step();
    valid = 0; store = 0;
    rst_n = 0;
    #1;
    got = {req, we, be, daddr, dwdata, done, rdata_o, mis, berr};
    checks++;
    if (got !== '0) begin
      errors++; $display("FAIL reset_mid_outputs: got %h expected 0", got);
    end
    step();
    rst_n = 1;
    rvalid = 1; rdata = 32'h11111111;
    step();
    rvalid = 0;
    present(0, 2'b10, 0, 32'h800, 32'h0);
    #1;
    checks++;
    if ({done, req, stall, ready} !== 4'b0001) begin
      errors++; $display("FAIL reset_mid_stray: got %b expected 0001", {done, req, stall, ready});
    end
    valid = 0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 0;
    idle_inputs();
    test_reset();
    test_word_load();
    test_byte_load(1'b0, 32'hFFFFFF80);
    test_byte_load(1'b1, 32'h00000080);
    test_half_store();
    test_misaligned();
    test_flush_wait();
    test_flush_req();
    test_flush_idle_stall();
    test_bus_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
